// File: rtl/sd_uart_cmd_sched.sv
// Purpose: parses 9-byte UART command frames (opcode, ADDR, LEN big-endian),
//          issues one write/read request to card_driver, waits for the transfer
//          to finish and returns a one-byte status to the UART transmitter.
// Latency: last RX byte at n -> arguments checked at n+1 -> WR_STB/RD_STB from n+2.
// Backpressure: RX is never stalled (bytes outside IDLE/ARG are counted in DROP_CNT);
//               the status byte waits in REPLY until TX_RDY.
// Ports: CLK/RST (sync, active-high); RX_STB/RX_DAT byte input; TX_STB/TX_DAT/TX_RDY
//        status output; WR_*/RD_* request/ack pairs; XFER_BUSY transfer-in-progress;
//        DROP_CNT saturating discarded-byte count.
module sd_uart_cmd_sched #(
  parameter logic [31:0] MAX_LENGTH = 32'd1048576,
  parameter int unsigned GAP_CYCLES = 5000000,
  parameter int unsigned ACK_CYCLES = 50000000,
  parameter int unsigned SETTLE     = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_STB,
  input  logic [7:0]  RX_DAT,
  output logic        TX_STB,
  output logic [7:0]  TX_DAT,
  input  logic        TX_RDY,
  output logic        WR_STB,
  output logic [31:0] WR_ADDR,
  output logic [31:0] WR_LENGTH,
  input  logic        WR_ACK,
  output logic        RD_STB,
  output logic [31:0] RD_ADDR,
  output logic [31:0] RD_LENGTH,
  input  logic        RD_ACK,
  input  logic        XFER_BUSY,
  output logic [7:0]  DROP_CNT
);

  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] ACK_LAST = 32'(ACK_CYCLES - 1);
  localparam logic [31:0] SETTLE_N = 32'(SETTLE);

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] ST_OK     = 8'h4B;
  localparam logic [7:0] ST_BADARG = 8'h45;
  localparam logic [7:0] ST_BADOP  = 8'h3F;
  localparam logic [7:0] ST_GAP    = 8'h54;
  localparam logic [7:0] ST_ACKTO  = 8'h58;

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_CHECK, S_REQ, S_WAIT, S_REPLY} state_t;

  state_t      state_q, state_d;
  logic        dir_wr_q, dir_wr_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] sr_q, sr_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] ack_q, ack_d;
  logic [31:0] settle_q, settle_d;
  logic        low_q, low_d;
  logic [7:0]  status_q, status_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_len_q, wr_len_d;
  logic [31:0] rd_addr_q, rd_addr_d, rd_len_q, rd_len_d;
  logic [7:0]  drop_q, drop_d;

  logic [31:0] frame_addr, frame_len;
  logic [32:0] frame_end;
  logic        bad_args, acked;

  assign frame_addr = sr_q[63:32];
  assign frame_len  = sr_q[31:0];
  // 33-bit end address so a transfer ending exactly at 2^32 is still legal.
  assign frame_end  = {1'b0, frame_addr} + {1'b0, frame_len};
  assign bad_args   = (frame_len == 32'd0) || (frame_len > MAX_LENGTH) ||
                      (frame_end > 33'h1_0000_0000);
  // Only an ACK seen against a raised strobe counts.
  assign acked      = (wr_stb_q & WR_ACK) | (rd_stb_q & RD_ACK);

  always_comb begin
    state_d   = state_q;
    dir_wr_d  = dir_wr_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    gap_d     = gap_q;
    ack_d     = ack_q;
    settle_d  = settle_q;
    low_d     = low_q;
    status_d  = status_q;
    wr_stb_d  = wr_stb_q;
    rd_stb_d  = rd_stb_q;
    wr_addr_d = wr_addr_q;
    wr_len_d  = wr_len_q;
    rd_addr_d = rd_addr_q;
    rd_len_d  = rd_len_q;
    drop_d    = drop_q;

    if (RX_STB && (state_q inside {S_CHECK, S_REQ, S_WAIT, S_REPLY}) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (RX_STB) begin
          if ((RX_DAT == OP_WRITE) || (RX_DAT == OP_READ)) begin
            dir_wr_d = (RX_DAT == OP_WRITE);
            idx_d    = 3'd0;
            gap_d    = 32'd0;
            state_d  = S_ARG;
          end else begin
            status_d = ST_BADOP;
            state_d  = S_REPLY;
          end
        end
      end
      S_ARG: begin
        // A byte arriving on the timeout cycle wins over the timeout.
        if (RX_STB) begin
          sr_d  = {sr_q[55:0], RX_DAT};
          gap_d = 32'd0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_CHECK;
        end else if (gap_q == GAP_LAST) begin
          status_d = ST_GAP;
          state_d  = S_REPLY;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_CHECK: begin
        if (bad_args) begin
          status_d = ST_BADARG;
          state_d  = S_REPLY;
        end else begin
          if (dir_wr_q) begin
            wr_addr_d = frame_addr;
            wr_len_d  = frame_len;
            wr_stb_d  = 1'b1;
          end else begin
            rd_addr_d = frame_addr;
            rd_len_d  = frame_len;
            rd_stb_d  = 1'b1;
          end
          ack_d   = 32'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (acked) begin
          wr_stb_d = 1'b0;
          rd_stb_d = 1'b0;
          settle_d = 32'd0;
          low_d    = 1'b0;
          state_d  = S_WAIT;
        end else if (ack_q == ACK_LAST) begin
          wr_stb_d = 1'b0;
          rd_stb_d = 1'b0;
          status_d = ST_ACKTO;
          state_d  = S_REPLY;
        end else begin
          ack_d = ack_q + 32'd1;
        end
      end
      S_WAIT: begin
        // XFER_BUSY may lag the ACK, so it is ignored for SETTLE cycles and then
        // must read low twice in a row before the transfer counts as done.
        if (settle_q < SETTLE_N) begin
          settle_d = settle_q + 32'd1;
        end else if (!XFER_BUSY) begin
          if (low_q) begin
            status_d = ST_OK;
            state_d  = S_REPLY;
          end else begin
            low_d = 1'b1;
          end
        end else begin
          low_d = 1'b0;
        end
      end
      S_REPLY: begin
        if (TX_RDY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      dir_wr_q  <= 1'b0;
      idx_q     <= 3'd0;
      sr_q      <= 64'd0;
      gap_q     <= 32'd0;
      ack_q     <= 32'd0;
      settle_q  <= 32'd0;
      low_q     <= 1'b0;
      status_q  <= 8'd0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_len_q  <= 32'd0;
      rd_addr_q <= 32'd0;
      rd_len_q  <= 32'd0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      dir_wr_q  <= dir_wr_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      settle_q  <= settle_d;
      low_q     <= low_d;
      status_q  <= status_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_len_q  <= wr_len_d;
      rd_addr_q <= rd_addr_d;
      rd_len_q  <= rd_len_d;
      drop_q    <= drop_d;
    end
  end

  // The strobe is decoded from REPLY so it coincides with the handshake cycle;
  // RST suppresses a byte that would otherwise go out while reset is sampled.
  assign TX_STB    = (state_q == S_REPLY) && TX_RDY && !RST;
  assign TX_DAT    = status_q;
  assign WR_STB    = wr_stb_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_LENGTH = wr_len_q;
  assign RD_STB    = rd_stb_q;
  assign RD_ADDR   = rd_addr_q;
  assign RD_LENGTH = rd_len_q;
  assign DROP_CNT  = drop_q;

endmodule

// File: tb/tb_sd_uart_cmd_sched.sv
module tb_sd_uart_cmd_sched;

  localparam int GAP  = 40;
  localparam int ACKC = 60;
  localparam int SET  = 4;
  localparam logic [31:0] MAXL = 32'd1048576;

  localparam logic [7:0] OP_W = 8'h57, OP_R = 8'h52, OP_Z = 8'h5A;
  localparam logic [7:0] ST_K = 8'h4B, ST_E = 8'h45, ST_Q = 8'h3F, ST_T = 8'h54, ST_X = 8'h58;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        RX_STB = 1'b0;
  logic [7:0]  RX_DAT = 8'd0;
  logic        TX_RDY = 1'b1, WR_ACK = 1'b0, RD_ACK = 1'b0, XFER_BUSY = 1'b0;
  logic        TX_STB, WR_STB, RD_STB;
  logic [7:0]  TX_DAT, DROP_CNT;
  logic [31:0] WR_ADDR, WR_LENGTH, RD_ADDR, RD_LENGTH;

  sd_uart_cmd_sched #(
    .MAX_LENGTH(MAXL), .GAP_CYCLES(GAP), .ACK_CYCLES(ACKC), .SETTLE(SET)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_STB(RX_STB), .RX_DAT(RX_DAT),
    .TX_STB(TX_STB), .TX_DAT(TX_DAT), .TX_RDY(TX_RDY),
    .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_LENGTH(WR_LENGTH), .WR_ACK(WR_ACK),
    .RD_STB(RD_STB), .RD_ADDR(RD_ADDR), .RD_LENGTH(RD_LENGTH), .RD_ACK(RD_ACK),
    .XFER_BUSY(XFER_BUSY), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int tx_cnt = 0, last_tx_cyc = 0, wr_cyc = 0, rd_cyc = 0, both_cnt = 0;
  logic [7:0] last_tx = 8'd0;
  int last_byte_cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Observer on the falling edge: status pulses, strobe-high cycle counts.
  always @(negedge CLK) begin
    if (TX_STB) begin
      tx_cnt = tx_cnt + 1;
      last_tx = TX_DAT;
      last_tx_cyc = cyc;
    end
    if (WR_STB) wr_cyc = wr_cyc + 1;
    if (RD_STB) rd_cyc = rd_cyc + 1;
    if (WR_STB && RD_STB) both_cnt = both_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_STB = 1'b1;
    RX_DAT = b;
    last_byte_cyc = cyc;
    tick(1);
    RX_STB = 1'b0;
    RX_DAT = 8'd0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] l,
                            input int gap);
    logic [7:0] fb[9];
    fb[0] = op;
    for (int i = 0; i < 4; i++) begin
      fb[1 + i] = a[31 - 8 * i -: 8];
      fb[5 + i] = l[31 - 8 * i -: 8];
    end
    for (int i = 0; i < 9; i++) begin
      send_byte(fb[i]);
      if (i != 8 && gap > 0) tick(gap);
    end
  endtask

  task automatic wait_tx(input int start, input int budget, output logic [7:0] d,
                         output bit got, output int at);
    for (int i = 0; i < budget; i++) begin
      if (tx_cnt != start) break;
      tick(1);
    end
    got = (tx_cnt != start);
    d   = last_tx;
    at  = last_tx_cyc;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(1);
    n_tests++;
    if (TX_STB !== 1'b0 || TX_DAT !== 8'd0)
      begin n_fail++; $display("FAIL reset_tx: stb=%b dat=%h expected 0/00", TX_STB, TX_DAT); end
    n_tests++;
    if (WR_STB !== 1'b0 || RD_STB !== 1'b0)
      begin n_fail++; $display("FAIL reset_stb: wr=%b rd=%b expected 0/0", WR_STB, RD_STB); end
    n_tests++;
    if ({WR_ADDR, WR_LENGTH, RD_ADDR, RD_LENGTH} !== 128'd0)
      begin n_fail++; $display("FAIL reset_addr_len: %h %h %h %h expected all 0", WR_ADDR, WR_LENGTH, RD_ADDR, RD_LENGTH); end
    n_tests++;
    if (DROP_CNT !== 8'd0)
      begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", DROP_CNT); end
  endtask

  task automatic test_valid_write();
    int tx0, rd0, at; logic [7:0] d, e; bit got;
    tx0 = tx_cnt; rd0 = rd_cyc;
    exp_q.push_back(ST_K);
    send_frame(OP_W, 32'h0000_0100, 32'd100, 0);
    n_tests++;
    if (WR_STB !== 1'b0)
      begin n_fail++; $display("FAIL write_stb_check_cycle: got %b expected 0", WR_STB); end
    tick(1);
    n_tests++;
    if (WR_STB !== 1'b1 || WR_ADDR !== 32'h100 || WR_LENGTH !== 32'd100)
      begin n_fail++; $display("FAIL write_req: stb=%b addr=%h len=%0d expected 1/100/100", WR_STB, WR_ADDR, WR_LENGTH); end
    tick(5);
    n_tests++;
    if (WR_STB !== 1'b1)
      begin n_fail++; $display("FAIL write_stb_hold: got %b expected 1", WR_STB); end
    WR_ACK = 1'b1; XFER_BUSY = 1'b1;
    tick(1);
    WR_ACK = 1'b0;
    n_tests++;
    if (WR_STB !== 1'b0)
      begin n_fail++; $display("FAIL write_stb_after_ack: got %b expected 0", WR_STB); end
    tick(50);
    n_tests++;
    if (tx_cnt != tx0)
      begin n_fail++; $display("FAIL write_busy_hold: tx pulses %0d expected 0", tx_cnt - tx0); end
    XFER_BUSY = 1'b0;
    wait_tx(tx0, 50, d, got, at);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || d !== e)
      begin n_fail++; $display("FAIL write_status: got %h (seen=%0d) expected %h", d, got, e); end
    tick(10);
    n_tests++;
    if (tx_cnt - tx0 != 1 || rd_cyc != rd0)
      begin n_fail++; $display("FAIL write_single_pulse: tx=%0d rd_cycles=%0d expected 1/0", tx_cnt - tx0, rd_cyc - rd0); end
  endtask

  task automatic test_read_boundary();
    int tx0, rd0, wr0, at, ack_cyc; logic [7:0] d, e; bit got;
    tx0 = tx_cnt; rd0 = rd_cyc; wr0 = wr_cyc;
    exp_q.push_back(ST_K);
    send_frame(OP_R, 32'hFFFF_FF00, 32'h0000_0100, 0);
    tick(1);
    n_tests++;
    if (RD_STB !== 1'b1 || RD_ADDR !== 32'hFFFF_FF00 || RD_LENGTH !== 32'h100 ||
        WR_ADDR !== 32'h100 || WR_LENGTH !== 32'd100)
      begin n_fail++; $display("FAIL read_req: stb=%b addr=%h len=%h wr=%h/%h expected 1/ffffff00/100 wr 100/64", RD_STB, RD_ADDR, RD_LENGTH, WR_ADDR, WR_LENGTH); end
    RD_ACK = 1'b1;
    ack_cyc = cyc;
    tick(1);
    RD_ACK = 1'b0;
    n_tests++;
    if (RD_STB !== 1'b0 || rd_cyc - rd0 != 1)
      begin n_fail++; $display("FAIL read_ack_first_cycle: stb=%b high_cycles=%0d expected 0/1", RD_STB, rd_cyc - rd0); end
    wait_tx(tx0, 50, d, got, at);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || d !== e || at - ack_cyc != SET + 3)
      begin n_fail++; $display("FAIL read_status_turnaround: got %h after %0d cycles expected %h after %0d", d, at - ack_cyc, e, SET + 3); end
    tx0 = tx_cnt; rd0 = rd_cyc;
    exp_q.push_back(ST_E);
    send_frame(OP_R, 32'hFFFF_FF00, 32'h0000_0101, 0);
    wait_tx(tx0, 20, d, got, at);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || d !== e || rd_cyc != rd0 || wr_cyc != wr0)
      begin n_fail++; $display("FAIL read_overflow: got %h rd=%0d wr=%0d expected %h/0/0", d, rd_cyc - rd0, wr_cyc - wr0, e); end
  endtask

  task automatic test_bad_inputs();
    logic [7:0]  ops[3]  = '{OP_W, OP_R, OP_Z};
    logic [31:0] lens[3] = '{32'd0, MAXL + 32'd1, 32'd16};
    logic [7:0]  exps[3] = '{ST_E, ST_E, ST_Q};
    int tx0, wr0, rd0, at; logic [7:0] d, e; bit got;
    for (int i = 0; i < 3; i++) begin
      tx0 = tx_cnt; wr0 = wr_cyc; rd0 = rd_cyc;
      exp_q.push_back(exps[i]);
      if (ops[i] == OP_Z) send_byte(ops[i]);
      else send_frame(ops[i], 32'h0, lens[i], 0);
      wait_tx(tx0, 20, d, got, at);
      e = exp_q.pop_front();
      n_tests++;
      if (!got || d !== e || wr_cyc != wr0 || rd_cyc != rd0)
        begin n_fail++; $display("FAIL bad_input_%0d: got %h wr=%0d rd=%0d expected %h/0/0", i, d, wr_cyc - wr0, rd_cyc - rd0, e); end
    end
  endtask

  task automatic test_gap_timeout();
    int tx0, c, at; logic [7:0] d, e; bit got;
    tx0 = tx_cnt;
    exp_q.push_back(ST_T);
    send_byte(OP_W); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    c = last_byte_cyc;
    wait_tx(tx0, GAP + 20, d, got, at);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || d !== e || at - c != GAP + 1)
      begin n_fail++; $display("FAIL gap_timeout: got %h after %0d cycles expected %h after %0d", d, at - c, e, GAP + 1); end
    // Bytes spaced so each lands on the would-be timeout cycle; LEN = MAX_LENGTH.
    tx0 = tx_cnt;
    exp_q.push_back(ST_K);
    send_frame(OP_W, 32'h0000_2000, MAXL, GAP - 1);
    tick(1);
    n_tests++;
    if (WR_STB !== 1'b1 || WR_ADDR !== 32'h2000 || WR_LENGTH !== MAXL || tx_cnt != tx0)
      begin n_fail++; $display("FAIL gap_edge_frame: stb=%b addr=%h len=%h tx=%0d expected 1/2000/%h/0", WR_STB, WR_ADDR, WR_LENGTH, tx_cnt - tx0, MAXL); end
    WR_ACK = 1'b1;
    tick(1);
    WR_ACK = 1'b0;
    wait_tx(tx0, 30, d, got, at);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || d !== e)
      begin n_fail++; $display("FAIL gap_edge_status: got %h expected %h", d, e); end
  endtask

  task automatic test_ack_timeout();
    int tx0, wr0, at, rdy_cyc; logic [7:0] d, e; bit got;
    tx0 = tx_cnt; wr0 = wr_cyc;
    TX_RDY = 1'b0;
    exp_q.push_back(ST_X);
    send_frame(OP_W, 32'h0000_0500, 32'h0000_0200, 0);
    tick(ACKC + 5);
    n_tests++;
    if (WR_STB !== 1'b0 || wr_cyc - wr0 != ACKC)
      begin n_fail++; $display("FAIL ack_timeout_len: stb=%b high_cycles=%0d expected 0/%0d", WR_STB, wr_cyc - wr0, ACKC); end
    tick(15);
    n_tests++;
    if (tx_cnt != tx0)
      begin n_fail++; $display("FAIL ack_timeout_tx_rdy_low: tx pulses %0d expected 0", tx_cnt - tx0); end
    TX_RDY = 1'b1;
    rdy_cyc = cyc;
    wait_tx(tx0, 10, d, got, at);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || d !== e || at != rdy_cyc)
      begin n_fail++; $display("FAIL ack_timeout_status: got %h at +%0d expected %h at +0", d, at - rdy_cyc, e); end
  endtask

  task automatic test_drops();
    int tx0, wr0, at, sent; logic [7:0] d, e; bit got;
    tx0 = tx_cnt; sent = 0;
    exp_q.push_back(ST_K);
    send_frame(OP_W, 32'h0000_0040, 32'h0000_0040, 0);
    tick(1);
    WR_ACK = 1'b1; XFER_BUSY = 1'b1;
    tick(1);
    WR_ACK = 1'b0;
    wr0 = wr_cyc;
    for (int i = 0; i < 10; i++) begin send_byte(OP_W); sent++; end
    n_tests++;
    if (DROP_CNT !== 8'((sent > 255) ? 255 : sent))
      begin n_fail++; $display("FAIL drop_count_10: got %0d expected %0d", DROP_CNT, sent); end
    for (int i = 0; i < 290; i++) begin send_byte(OP_R); sent++; end
    n_tests++;
    if (DROP_CNT !== 8'((sent > 255) ? 255 : sent))
      begin n_fail++; $display("FAIL drop_count_sat: got %0d expected 255", DROP_CNT); end
    XFER_BUSY = 1'b0;
    wait_tx(tx0, 30, d, got, at);
    e = exp_q.pop_front();
    tick(10);
    n_tests++;
    if (!got || d !== e || tx_cnt - tx0 != 1 || wr_cyc != wr0)
      begin n_fail++; $display("FAIL drop_status: got %h tx=%0d wr=%0d expected %h/1/0", d, tx_cnt - tx0, wr_cyc - wr0, e); end
  endtask

  task automatic test_reset_mid();
    int tx0, at; logic [7:0] d, e; bit got;
    tx0 = tx_cnt;
    send_frame(OP_R, 32'h0000_0800, 32'h0000_0080, 0);
    tick(1);
    n_tests++;
    if (RD_STB !== 1'b1)
      begin n_fail++; $display("FAIL reset_mid_pre: rd_stb=%b expected 1", RD_STB); end
    RST = 1'b1;
    tick(1);
    n_tests++;
    if (RD_STB !== 1'b0 || WR_STB !== 1'b0 || TX_STB !== 1'b0 || TX_DAT !== 8'd0 ||
        {WR_ADDR, WR_LENGTH, RD_ADDR, RD_LENGTH} !== 128'd0)
      begin n_fail++; $display("FAIL reset_mid_outputs: rd=%b wr=%b tx=%b/%h addr/len=%h/%h/%h/%h expected all 0", RD_STB, WR_STB, TX_STB, TX_DAT, WR_ADDR, WR_LENGTH, RD_ADDR, RD_LENGTH); end
    n_tests++;
    if (DROP_CNT !== 8'd0)
      begin n_fail++; $display("FAIL reset_mid_drop: got %0d expected 0", DROP_CNT); end
    RST = 1'b0;
    tick(20);
    n_tests++;
    if (tx_cnt != tx0 || RD_STB !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid_no_tx: tx=%0d rd=%b expected 0/0", tx_cnt - tx0, RD_STB); end
    exp_q.push_back(ST_Q);
    send_byte(OP_Z);
    wait_tx(tx0, 20, d, got, at);
    e = exp_q.pop_front();
    n_tests++;
    if (!got || d !== e)
      begin n_fail++; $display("FAIL reset_mid_recover: got %h expected %h", d, e); end
  endtask

  task automatic test_exclusive();
    n_tests++;
    if (both_cnt != 0)
      begin n_fail++; $display("FAIL exclusive_stb: both high for %0d cycles expected 0", both_cnt); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_valid_write();
    test_read_boundary();
    test_bad_inputs();
    test_gap_timeout();
    test_ack_timeout();
    test_drops();
    test_reset_mid();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
